// File: rtl/regfile_wr_scheduler_pkg.sv
// rtl/regfile_wr_scheduler_pkg.sv - shared defaults, state enum and clog2 helper for the write scheduler
package rf_ctrl_pkg;

   localparam int NREQ_DEF  = 4;
   localparam int DEPTH_DEF = 32;
   localparam int DW_DEF    = 32;
   localparam int AW_DEF    = 5;

   typedef enum logic {
      IDLE,
      CLEAR
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/regfile_wr_scheduler_if.sv
// rtl/regfile_wr_scheduler_if.sv - requester and register-file write-port bundle
interface regfile_wr_scheduler_if
   import rf_ctrl_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF
);
   logic [NREQ-1:0]    req;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    gnt;
   logic               clr_start;
   logic               clr_busy;
   logic               clr_done;
   logic               rf_we;
   logic [AW-1:0]      rf_waddr;
   logic [DW-1:0]      rf_wdata;

   modport master (
      output req, req_addr, req_data, clr_start,
      input  gnt, clr_busy, clr_done, rf_we, rf_waddr, rf_wdata
   );

   modport slave (
      input  req, req_addr, req_data, clr_start,
      output gnt, clr_busy, clr_done, rf_we, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/regfile_wr_scheduler_rr_pick.sv
// rtl/regfile_wr_scheduler_rr_pick.sv - combinational round-robin picker
// Rotates requests so rr_ptr sits at bit 0, isolates the lowest set bit, rotates back.
module rr_pick
   import rf_ctrl_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int PW   = clog2(NREQ)
) (
   input  logic [NREQ-1:0] eff,
   input  logic [PW-1:0]   rr_ptr,
   output logic [NREQ-1:0] win,
   output logic            valid
);
   logic [NREQ-1:0] rot;
   logic [NREQ-1:0] rot_win;

   always_comb begin
      rot     = NREQ'({eff, eff} >> rr_ptr);
      rot_win = rot & (-rot);
      win     = NREQ'(({rot_win, rot_win} << rr_ptr) >> NREQ);
      valid   = |eff;
   end
endmodule

// File: rtl/regfile_wr_scheduler.sv
// rtl/regfile_wr_scheduler.sv - round-robin owner of the register-file write port with clear sweep
module regfile_wr_scheduler
   import rf_ctrl_pkg::*;
#(
   parameter int NREQ         = NREQ_DEF,
   parameter int DEPTH        = DEPTH_DEF,
   parameter int DW           = DW_DEF,
   parameter int AW           = AW_DEF,
   parameter int R0_HARDWIRED = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   regfile_wr_scheduler_if.slave  bus
);
   localparam int          PW      = clog2(NREQ);
   localparam logic [AW:0] CNT_END = (AW + 1)'(DEPTH);

   state_t            state, state_nxt;
   logic [AW:0]       cnt, cnt_nxt;
   logic [PW-1:0]     rr_ptr, rr_ptr_nxt;
   logic [NREQ-1:0]   gnt_q, gnt_nxt;
   logic              we_q, we_nxt;
   logic [AW-1:0]     waddr_q, waddr_nxt;
   logic [DW-1:0]     wdata_q, wdata_nxt;
   logic              busy_q, busy_nxt;
   logic              done_q, done_nxt;

   logic [NREQ-1:0]   eff;
   logic [NREQ-1:0]   win;
   logic              win_valid;
   logic [AW-1:0]     sel_addr;
   logic [DW-1:0]     sel_data;
   logic [PW-1:0]     ptr_after;

   // A lane granted last cycle is masked so a held request is not served twice.
   assign eff = bus.req & ~gnt_q;

   rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .eff    (eff),
      .rr_ptr (rr_ptr),
      .win    (win),
      .valid  (win_valid)
   );

   always_comb begin
      sel_addr  = '0;
      sel_data  = '0;
      ptr_after = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win[i]) begin
            sel_addr  = bus.req_addr[i*AW +: AW];
            sel_data  = bus.req_data[i*DW +: DW];
            ptr_after = (i == NREQ - 1) ? '0 : PW'(i + 1);
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      rr_ptr_nxt = rr_ptr;
      gnt_nxt    = '0;
      we_nxt     = 1'b0;
      waddr_nxt  = waddr_q;
      wdata_nxt  = wdata_q;
      busy_nxt   = 1'b0;
      done_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.clr_start) begin
               state_nxt = CLEAR;
               cnt_nxt   = (AW + 1)'(1);
               busy_nxt  = 1'b1;
               we_nxt    = 1'b1;
               waddr_nxt = '0;
               wdata_nxt = '0;
            end else if (win_valid) begin
               gnt_nxt    = win;
               // Writes to a hardwired r0 are consumed but never reach the file.
               we_nxt     = !((R0_HARDWIRED != 0) && (sel_addr == '0));
               waddr_nxt  = sel_addr;
               wdata_nxt  = sel_data;
               rr_ptr_nxt = ptr_after;
            end
         end
         CLEAR: begin
            if (cnt == CNT_END) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               done_nxt  = 1'b1;
            end else begin
               busy_nxt  = 1'b1;
               we_nxt    = 1'b1;
               waddr_nxt = cnt[AW-1:0];
               wdata_nxt = '0;
               cnt_nxt   = cnt + (AW + 1)'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         rr_ptr  <= '0;
         gnt_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         rr_ptr  <= rr_ptr_nxt;
         gnt_q   <= gnt_nxt;
         we_q    <= we_nxt;
         waddr_q <= waddr_nxt;
         wdata_q <= wdata_nxt;
         busy_q  <= busy_nxt;
         done_q  <= done_nxt;
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.rf_we    = we_q;
   assign bus.rf_waddr = waddr_q;
   assign bus.rf_wdata = wdata_q;
   assign bus.clr_busy = busy_q;
   assign bus.clr_done = done_q;
endmodule

// File: tb/tb_regfile_wr_scheduler.sv
// tb/tb_regfile_wr_scheduler.sv - directed bench with a behavioural write-port model
module tb_regfile_wr_scheduler;
   localparam int NREQ  = 4;
   localparam int DEPTH = 32;
   localparam int DW    = 32;
   localparam int AW    = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   bit   chk_en = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;

   regfile_wr_scheduler_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

   regfile_wr_scheduler #(
      .NREQ(NREQ), .DEPTH(DEPTH), .DW(DW), .AW(AW), .R0_HARDWIRED(1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Model: written from the port-level rules, not from the RTL structure.
   int              m_ptr = 0;
   bit              m_clr = 1'b0;
   int              m_cnt = 0;
   logic [NREQ-1:0] e_gnt = '0;
   logic            e_we = 1'b0, e_busy = 1'b0, e_done = 1'b0;
   logic [AW-1:0]   e_addr = '0;
   logic [DW-1:0]   e_data = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_ptr = 0; m_clr = 1'b0; m_cnt = 0;
         e_gnt = '0; e_we = 1'b0; e_busy = 1'b0; e_done = 1'b0;
         e_addr = '0; e_data = '0;
      end else begin
         logic [NREQ-1:0] prev_gnt;
         int  w;
         prev_gnt = e_gnt;
         e_gnt  = '0;
         e_done = 1'b0;
         e_we   = 1'b0;
         if (m_clr) begin
            if (m_cnt == DEPTH) begin
               m_clr = 1'b0; e_busy = 1'b0; e_done = 1'b1;
            end else begin
               e_we = 1'b1; e_addr = AW'(m_cnt); e_data = '0; m_cnt++;
            end
         end else if (bus.clr_start) begin
            m_clr = 1'b1; m_cnt = 1; e_busy = 1'b1;
            e_we = 1'b1; e_addr = '0; e_data = '0;
         end else begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
               int i;
               i = (m_ptr + k) % NREQ;
               if (w < 0 && bus.req[i] && !prev_gnt[i]) w = i;
            end
            if (w >= 0) begin
               e_gnt[w] = 1'b1;
               e_addr   = bus.req_addr[w*AW +: AW];
               e_data   = bus.req_data[w*DW +: DW];
               e_we     = (e_addr != 0);
               m_ptr    = (w + 1) % NREQ;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("gnt",      64'(bus.gnt),      64'(e_gnt));
         chk("rf_we",    64'(bus.rf_we),    64'(e_we));
         chk("clr_busy", 64'(bus.clr_busy), 64'(e_busy));
         chk("clr_done", 64'(bus.clr_done), 64'(e_done));
         if (e_we) begin
            chk("rf_waddr", 64'(bus.rf_waddr), 64'(e_addr));
            chk("rf_wdata", 64'(bus.rf_wdata), 64'(e_data));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [NREQ-1:0] rr_seq [4];
      int sweep;
      int dn;
      rr_seq[0] = 4'b0010; rr_seq[1] = 4'b0100; rr_seq[2] = 4'b1000; rr_seq[3] = 4'b0001;

      bus.clr_start = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_addr[i*AW +: AW] = AW'(10 + i);
         bus.req_data[i*DW +: DW] = 32'h1000_0000 + DW'(i);
      end
      bus.req = 4'b1111;

      // Reset held with all requests pending
      cyc(); cyc();
      chk("rst_gnt",   64'(bus.gnt), 64'h0);
      chk("rst_we",    64'(bus.rf_we), 64'h0);
      chk("rst_waddr", 64'(bus.rf_waddr), 64'h0);
      chk("rst_wdata", 64'(bus.rf_wdata), 64'h0);
      chk("rst_busy",  64'(bus.clr_busy), 64'h0);
      chk("rst_done",  64'(bus.clr_done), 64'h0);
      rst = 1'b1;
      chk_en = 1'b1;

      // Round robin with all lanes requesting
      cyc();
      chk("rr_first_gnt", 64'(bus.gnt), 64'h1);
      chk("rr_first_addr", 64'(bus.rf_waddr), 64'd10);
      chk("rr_first_data", 64'(bus.rf_wdata), 64'h1000_0000);
      for (int s = 0; s < 4; s++) begin
         cyc();
         chk("rr_seq_gnt", 64'(bus.gnt), 64'(rr_seq[s]));
      end
      bus.req = '0;
      cyc();

      // Single lane held high: served every other cycle
      bus.req_addr[2*AW +: AW] = 5'd7;
      bus.req_data[2*DW +: DW] = 32'hA5A5_0001;
      bus.req = 4'b0100;
      cyc();
      chk("mask_we1", 64'(bus.rf_we), 64'h1);
      chk("mask_gnt1", 64'(bus.gnt), 64'h4);
      chk("mask_addr", 64'(bus.rf_waddr), 64'd7);
      chk("mask_data", 64'(bus.rf_wdata), 64'hA5A5_0001);
      cyc();
      chk("mask_we2", 64'(bus.rf_we), 64'h0);
      cyc();
      chk("mask_we3", 64'(bus.rf_we), 64'h1);
      bus.req = '0;
      cyc();

      // Address 0 consumed but not written; address 3 written
      bus.req_addr[1*AW +: AW] = 5'd0;
      bus.req = 4'b0010;
      cyc();
      chk("r0_gnt", 64'(bus.gnt), 64'h2);
      chk("r0_we", 64'(bus.rf_we), 64'h0);
      bus.req = '0;
      cyc();
      bus.req_addr[1*AW +: AW] = 5'd3;
      bus.req = 4'b0010;
      cyc();
      chk("r3_gnt", 64'(bus.gnt), 64'h2);
      chk("r3_we", 64'(bus.rf_we), 64'h1);
      chk("r3_addr", 64'(bus.rf_waddr), 64'd3);
      bus.req = '0;
      cyc();

      // Full clear with a competing request and a stray restart
      bus.clr_start = 1'b1;
      bus.req = 4'b0001;
      cyc();
      chk("clr_e0_gnt", 64'(bus.gnt), 64'h0);
      chk("clr_e0_busy", 64'(bus.clr_busy), 64'h1);
      sweep = (bus.rf_we && bus.rf_waddr == 0 && bus.rf_wdata == 0) ? 1 : 0;
      for (int k = 1; k < DEPTH; k++) begin
         bus.clr_start = (k == 5);
         cyc();
         if (bus.rf_we && bus.rf_waddr == AW'(k) && bus.rf_wdata == 0 && bus.clr_busy && bus.gnt == 0)
            sweep++;
      end
      bus.clr_start = 1'b0;
      chk("clr_sweep_count", 64'(sweep), 64'd32);
      cyc();
      chk("clr_done_pulse", 64'(bus.clr_done), 64'h1);
      chk("clr_end_busy", 64'(bus.clr_busy), 64'h0);
      chk("clr_end_gnt", 64'(bus.gnt), 64'h0);
      cyc();
      chk("clr_after_gnt", 64'(bus.gnt), 64'h1);
      chk("clr_after_done", 64'(bus.clr_done), 64'h0);
      chk("clr_after_addr", 64'(bus.rf_waddr), 64'd10);
      bus.req = '0;
      cyc();

      // Reset in the middle of a sweep
      bus.clr_start = 1'b1;
      cyc();
      bus.clr_start = 1'b0;
      for (int k = 1; k <= 10; k++) cyc();
      chk("midclr_addr", 64'(bus.rf_waddr), 64'd10);
      rst = 1'b0;
      #1;
      chk("midclr_rst_we", 64'(bus.rf_we), 64'h0);
      chk("midclr_rst_addr", 64'(bus.rf_waddr), 64'h0);
      chk("midclr_rst_busy", 64'(bus.clr_busy), 64'h0);
      cyc(); cyc();
      rst = 1'b1;
      bus.req = 4'b1001;
      cyc();
      chk("midclr_ptr0_gnt", 64'(bus.gnt), 64'h1);
      bus.req = '0;
      dn = 0;
      for (int k = 0; k < 40; k++) begin
         cyc();
         if (bus.clr_done) dn++;
      end
      chk("midclr_no_done", 64'(dn), 64'd0);
      chk("midclr_idle_busy", 64'(bus.clr_busy), 64'h0);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/regfile_wr_scheduler.md
Name: regfile_wr_scheduler

Overview:
Shares the single write port of the register file between NREQ requesters using round-robin arbitration. It also runs a clear sequence that zeroes every register, one address per cycle. All write-port outputs are registered on the rising edge of clk. This keeps them stable at the register file's falling-edge capture. The block sits directly in front of the register file's write port (we/addr/data).

Parameters:
NREQ, 4, number of write requesters (2..8)
DEPTH, 32, number of registers
DW, 32, data width
AW, 5, address width (= clog2(DEPTH))
R0_HARDWIRED, 1, if 1, writes to address 0 are granted but never issued (rf_we held 0)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-low
req  in  NREQ  per-requester write request; address/data held stable until grant
req_addr  in  NREQ*AW  packed target addresses; requester i at [i*AW +: AW]
req_data  in  NREQ*DW  packed write data; requester i at [i*DW +: DW]
gnt  out  NREQ  one-hot, registered; high in the cycle the requester's write is on the port
clr_start  in  1  request to zero all registers
clr_busy  out  1  high while the clear sequence runs
clr_done  out  1  one-cycle pulse after the last address is cleared
rf_we  out  1  register-file write enable
rf_waddr  out  AW  register-file write address
rf_wdata  out  DW  register-file write data

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rr_ptr=0, clear counter=0. All outputs 0 (gnt, clr_busy, clr_done, rf_we, rf_waddr, rf_wdata). These values hold while rst=0.
- States: IDLE (arbitrate), CLEAR (sweep).
- Arbitration in IDLE, at each posedge:
  - Effective request: eff[i] = req[i] & ~gnt[i]. A requester that currently holds a grant is masked, so a request is never double-served.
  - The winner is the first set eff[i], searching from rr_ptr upward with wrap (NREQ-1 wraps to 0).
  - Next cycle: gnt[winner]=1, rf_waddr=req_addr[winner], rf_wdata=req_data[winner], rf_we=1. Latency is 1 cycle from request sample to write.
  - rr_ptr = (winner+1) mod NREQ.
  - If no eff bit is set: gnt=0, rf_we=0, rr_ptr unchanged, rf_waddr/rf_wdata hold their previous values.
- Requester protocol: drop req, or present a new request, in the cycle after gnt. The same requester can win at most every other cycle; different requesters can win back-to-back.
- R0_HARDWIRED=1 and winner address==0: gnt still asserted (the request is consumed), rf_we=0.
- Clear sequence:
  - In IDLE, clr_start=1 at posedge e0: state->CLEAR, clr_busy=1. clr_start has priority over req, so no grant is issued at e0.
  - Outputs after e0+k (k=0..DEPTH-1): rf_we=1, rf_waddr=k, rf_wdata=0. The address-0 write is issued even when R0_HARDWIRED=1.
  - At e0+DEPTH: state->IDLE, rf_we=0, clr_busy=0, clr_done=1 for one cycle. No grant at this edge; arbitration resumes at e0+DEPTH+1.
  - gnt=0 throughout CLEAR. Pending requests wait and are never dropped. clr_start during CLEAR is ignored (no restart, no queue).
- Counter is AW+1 bits, so termination is exact for DEPTH=2^AW.
- rst asserted mid-clear or mid-grant: immediate return to reset values. The sweep is abandoned, not resumed.

Decomposition:
- Package rf_ctrl_pkg: DEPTH/DW/AW defaults, state enum {IDLE, CLEAR}, helper function clog2.
- Sub-module rr_pick (combinational): inputs eff[NREQ] and rr_ptr; outputs one-hot win and a valid flag.
- Sequential logic stays in regfile_wr_scheduler.

Test Plan:
- Reset: rst=0 with req=4'b1111 -> all outputs 0. Release rst; the first grant is gnt=0001 one cycle later.
- Round-robin: req=1111 held continuously, each requester re-requesting the cycle after its grant -> gnt sequence 0001,0010,0100,1000,0001. rf_waddr/rf_wdata match the granted lane each cycle.
- Masking: only req[2]=1, addr=7, data=32'hA5A5_0001, held high for 3 cycles -> writes in cycles 1 and 3 only, never in consecutive cycles.
- R0 hardwire: req[1]=1 with addr=0 -> gnt=0010 and rf_we=0. Same with addr=3 -> rf_we=1, rf_waddr=3.
- Clear: clr_start and req[0] pulsed at the same edge -> 32 cycles of rf_we=1, addresses 0..31, data 0, clr_busy=1. Then clr_done pulses once. gnt=0001 appears on the cycle after clr_done.
- Reset mid-clear: drop rst at address 10 -> outputs go to 0 immediately. After release: IDLE, clr_done never pulses, rr_ptr=0.
